ov7670_frame_ctrl: RTL and testbench
====================================

OV7670_FRAME_CTRL -- requirements
Module: ov7670_frame_ctrl

Interface
REQ-001 H_ACTIVE, 320, active pixels per line.
REQ-002 V_ACTIVE, 240, active lines per frame.
REQ-003 FB_DEPTH, 76800, pixels per frame buffer (H_ACTIVE*V_ACTIVE).
REQ-004 pclk  in  1  camera pixel clock; the only clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 vsync  in  1  camera frame sync; high is blanking.
REQ-007 href  in  1  camera line valid.
REQ-008 pix_we  in  1  one-cycle pixel-written strobe from the capture datapath.
REQ-009 start  in  1  one-cycle request to arm capture.
REQ-010 stop  in  1  one-cycle abort request.
REQ-011 continuous  in  1  1 = re-arm automatically after each frame.
REQ-012 capture_en  out  1  gates the capture datapath write enable.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-015 frame_err  out  1  sticky flag for a short or long frame.
REQ-016 frame_cnt  out  16  count of completed frames.
REQ-017 line_cnt  out  9  lines counted in the current frame.
REQ-018 pix_cnt  out  17  pixels counted in the current frame.
REQ-019 bank  out  1  frame buffer bank for the capture datapath to write.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT_VS, ACTIVE and DONE, with the state held in a register.
REQ-021 vsync and href SHALL each be registered once; edges are detected against the registered copy.
REQ-022 IDLE: start=1 -> WAIT_VS.
REQ-023 WAIT_VS: on a vsync falling edge -> ACTIVE in the same cycle; line_cnt and pix_cnt clear to 0.
REQ-024 ACTIVE: capture_en=1; each pix_we=1 increments pix_cnt, saturating at FB_DEPTH.
REQ-025 ACTIVE: pix_we=1 while pix_cnt==FB_DEPTH sets frame_err.
REQ-026 ACTIVE: an href falling edge increments line_cnt only if at least one pix_we occurred since the previous href rising edge; line_cnt saturates at V_ACTIVE.
REQ-027 ACTIVE: a vsync rising edge -> DONE; frame_err is set if pix_cnt!=FB_DEPTH or line_cnt!=V_ACTIVE.
REQ-028 DONE lasts exactly one cycle with frame_done=1, capture_en=0, and frame_cnt incremented (wraps 0xFFFF->0).
REQ-029 DONE -> WAIT_VS if continuous=1, else -> IDLE.
REQ-030 stop=1 in any state -> IDLE next cycle, with no frame_done and no frame_cnt change; pix_cnt and line_cnt are held.
REQ-031 If start and stop are both 1 in the same cycle, stop SHALL win.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 frame_err SHALL clear only on reset or on an accepted start.
REQ-034 capture_en SHALL be registered, with latency of 1 pclk from the state change.

Reset
REQ-035 rst=1 SHALL immediately force: state=IDLE, capture_en=0, busy=0, frame_done=0, frame_err=0, frame_cnt=0, line_cnt=0, pix_cnt=0, bank=0, and both edge registers=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.

Configuration
REQ-037 The macro OV7670_FRAME_DBUF_EN SHALL select ping-pong double buffering.
REQ-038 With OV7670_FRAME_DBUF_EN defined, bank toggles in the DONE cycle only when frame_err is 0, so a bad frame is overwritten.
REQ-039 Without OV7670_FRAME_DBUF_EN, bank is constant 0 and no toggle logic is built.

Structure
REQ-040 A shared package ov7670_pkg SHALL hold the H_ACTIVE/V_ACTIVE/FB_DEPTH constants and the FSM state encoding.
REQ-041 A sub-module ov7670_edge_det (registered vsync/href edge detector) SHALL be used; all other logic stays flat.

Verification
REQ-042 start, then a 240-line x 320-pixel frame -> frame_done 1 cycle after the vsync rise; frame_cnt=1, frame_err=0, pix_cnt=76800, line_cnt=240.
REQ-043 A frame with 239 lines -> frame_err=1; bank unchanged when DBUF enabled; frame_err cleared by the next start.
REQ-044 continuous=1 for 3 frames -> 3 frame_done pulses with no extra start; bank sequence 1,0,1 when DBUF enabled.
REQ-045 stop mid-ACTIVE at pix_cnt=1000 -> IDLE next cycle, capture_en=0, no frame_done, frame_cnt unchanged.
REQ-046 start and stop in the same cycle in IDLE -> remains IDLE, busy=0.
REQ-047 frame_cnt preloaded via forced 0xFFFF, then one good frame -> frame_cnt=0; rst pulsed mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared frame geometry constants and controller state encoding
package ov7670_pkg;

    localparam int H_ACTIVE = 320;
    localparam int V_ACTIVE = 240;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;

    localparam int PIX_W  = 17;
    localparam int LINE_W = 9;
    localparam int FCNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ov7670_edge_det.sv
// rtl/ov7670_edge_det.sv - registers vsync/href once and flags their edges against the registered copy
module ov7670_edge_det (
    input  logic pclk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic vs_fall,
    output logic hr_rise,
    output logic hr_fall
);

    logic vsync_q;
    logic href_q;

    // One-stage history of the camera sync lines
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vs_rise = vsync & ~vsync_q;
    assign vs_fall = ~vsync & vsync_q;
    assign hr_rise = href & ~href_q;
    assign hr_fall = ~href & href_q;

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// rtl/ov7670_frame_ctrl.sv - OV7670 capture frame controller; OV7670_FRAME_DBUF_EN enables ping-pong banks
module ov7670_frame_ctrl
    import ov7670_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int V_ACT = V_ACTIVE
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic        pix_we,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    output logic        capture_en,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [8:0]  line_cnt,
    output logic [16:0] pix_cnt,
    output logic        bank
);

    localparam logic [PIX_W-1:0]  FB_MAX   = PIX_W'(H_ACT * V_ACT);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACT);

    state_t state;
    state_t state_d;

    logic vs_rise;
    logic vs_fall;
    logic hr_rise;
    logic hr_fall;
    logic line_has_pix;

    logic start_acc;
    logic enter_active;
    logic in_active;
    logic enter_done;

    ov7670_edge_det u_edge_det (
        .pclk    (pclk),
        .rst     (rst),
        .vsync   (vsync),
        .href    (href),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_rise (hr_rise),
        .hr_fall (hr_fall)
    );

    // stop overrides every transition, including a simultaneous start
    assign start_acc    = (state == ST_IDLE) && start && !stop;
    assign enter_active = (state == ST_WAIT_VS) && vs_fall && !stop;
    assign in_active    = (state == ST_ACTIVE) && !stop;
    assign enter_done   = in_active && vs_rise;

    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);

    // State register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode; stop forces IDLE from anywhere
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (start)   state_d = ST_WAIT_VS;
            ST_WAIT_VS: if (vs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE:  if (vs_rise) state_d = ST_DONE;
            ST_DONE:    state_d = continuous ? ST_WAIT_VS : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d = ST_IDLE;
        end
    end

    // Write gate follows the registered next state so it drops in the DONE cycle
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            capture_en <= 1'b0;
        end else begin
            capture_en <= (state_d == ST_ACTIVE);
        end
    end

    // Pixel and line counters; cleared at frame start, frozen outside ACTIVE
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            line_has_pix <= 1'b0;
        end else if (enter_active) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            line_has_pix <= 1'b0;
        end else if (in_active) begin
            if (pix_we && (pix_cnt != FB_MAX)) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (pix_we) begin
                line_has_pix <= 1'b1;
            end else if (hr_rise) begin
                line_has_pix <= 1'b0;
            end
            if (hr_fall && (line_has_pix || pix_we) && (line_cnt != LINE_MAX)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    // Sticky error: overflow during the frame or wrong geometry at frame end
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (start_acc) begin
            frame_err <= 1'b0;
        end else if (in_active) begin
            if (pix_we && (pix_cnt == FB_MAX)) begin
                frame_err <= 1'b1;
            end
            if (vs_rise && ((pix_cnt != FB_MAX) || (line_cnt != LINE_MAX))) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Completed-frame counter, updated on entry so it is visible with frame_done
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (enter_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef OV7670_FRAME_DBUF_EN
    logic bank_q;

    // Swap banks only after a clean frame so a bad frame gets overwritten
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bank_q <= 1'b0;
        end else if ((state == ST_DONE) && !frame_err) begin
            bank_q <= ~bank_q;
        end
    end

    assign bank = bank_q;
`else
    assign bank = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// tb/tb_ov7670_frame_ctrl.sv - directed self-checking bench for ov7670_frame_ctrl on a 40x30 geometry
module tb_ov7670_frame_ctrl;

    localparam int H = 40;
    localparam int V = 30;
`ifdef OV7670_FRAME_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic        pix_we;
    logic        start;
    logic        stop;
    logic        continuous;
    logic        capture_en;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [8:0]  line_cnt;
    logic [16:0] pix_cnt;
    logic        bank;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;
    int pulses_ref;

    ov7670_frame_ctrl #(.H_ACT(H), .V_ACT(V)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .pix_we     (pix_we),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .capture_en (capture_en),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .line_cnt   (line_cnt),
        .pix_cnt    (pix_cnt),
        .bank       (bank)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (frame_done === 1'b1) done_pulses++;

    function automatic logic exp_bank(input logic v);
        return DBUF ? v : 1'b0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic run_lines(input int lines);
        for (int l = 0; l < lines; l++) begin
            href = 1'b1; pix_we = 1'b1; cyc(H);
            href = 1'b0; pix_we = 0; cyc(4);
        end
    endtask

    // vsync fall, lines, vsync rise; returns at the negedge inside DONE
    task automatic frame_body(input int lines);
        vsync = 1'b0; cyc(3);
        run_lines(lines);
        vsync = 1'b1; cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; href = 0; pix_we = 0; start = 0; stop = 0; continuous = 0;
        cyc(3);
        vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy got=%0h want=0", busy); end
        vectors++; if (capture_en !== 1'b0)  begin miscompares++; $display("FAIL rst_cap got=%0h want=0", capture_en); end
        vectors++; if (frame_done !== 1'b0)  begin miscompares++; $display("FAIL rst_done got=%0h want=0", frame_done); end
        vectors++; if (frame_cnt !== 16'd0)  begin miscompares++; $display("FAIL rst_fcnt got=%0h want=0", frame_cnt); end
        vectors++; if (pix_cnt !== 17'd0)    begin miscompares++; $display("FAIL rst_pix got=%0h want=0", pix_cnt); end
        vectors++; if (bank !== 1'b0)        begin miscompares++; $display("FAIL rst_bank got=%0h want=0", bank); end
        rst = 1'b0; cyc(2);
    endtask

    task automatic test_good_frame();
        pulse_start();
        vectors++; if (busy !== 1'b1)       begin miscompares++; $display("FAIL good_busy got=%0h want=1", busy); end
        vsync = 1'b0; cyc(3);
        vectors++; if (capture_en !== 1'b1) begin miscompares++; $display("FAIL good_cap got=%0h want=1", capture_en); end
        run_lines(V);
        vsync = 1'b1; cyc(1);
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL good_done got=%0h want=1", frame_done); end
        vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL good_fcnt got=%0h want=1", frame_cnt); end
        vectors++; if (frame_err !== 1'b0)  begin miscompares++; $display("FAIL good_err got=%0h want=0", frame_err); end
        vectors++; if (pix_cnt !== 17'd1200) begin miscompares++; $display("FAIL good_pix got=%0d want=1200", pix_cnt); end
        vectors++; if (line_cnt !== 9'd30)  begin miscompares++; $display("FAIL good_line got=%0d want=30", line_cnt); end
        vectors++; if (capture_en !== 1'b0) begin miscompares++; $display("FAIL good_cap_done got=%0h want=0", capture_en); end
        cyc(1);
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL good_done_len got=%0h want=0", frame_done); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL good_idle got=%0h want=0", busy); end
        vectors++; if (bank !== exp_bank(1'b1)) begin miscompares++; $display("FAIL good_bank got=%0h want=%0h", bank, exp_bank(1'b1)); end
    endtask

    task automatic test_short_frame();
        pulse_start();
        frame_body(V - 1);
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL short_done got=%0h want=1", frame_done); end
        vectors++; if (frame_err !== 1'b1)  begin miscompares++; $display("FAIL short_err got=%0h want=1", frame_err); end
        vectors++; if (line_cnt !== 9'd29)  begin miscompares++; $display("FAIL short_line got=%0d want=29", line_cnt); end
        vectors++; if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL short_fcnt got=%0h want=2", frame_cnt); end
        cyc(1);
        vectors++; if (bank !== exp_bank(1'b1)) begin miscompares++; $display("FAIL short_bank got=%0h want=%0h", bank, exp_bank(1'b1)); end
        vectors++; if (frame_err !== 1'b1)  begin miscompares++; $display("FAIL short_sticky got=%0h want=1", frame_err); end
        pulse_start();
        vectors++; if (frame_err !== 1'b0)  begin miscompares++; $display("FAIL short_clear got=%0h want=0", frame_err); end
    endtask

    // Entered in WAIT_VS from the clearing start of the previous test
    task automatic test_stop();
        pulses_ref = done_pulses;
        vsync = 1'b0; cyc(3);
        run_lines(25);
        vectors++; if (pix_cnt !== 17'd1000) begin miscompares++; $display("FAIL stop_pre_pix got=%0d want=1000", pix_cnt); end
        stop = 1'b1; cyc(1); stop = 1'b0;
        vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL stop_busy got=%0h want=0", busy); end
        vectors++; if (capture_en !== 1'b0)  begin miscompares++; $display("FAIL stop_cap got=%0h want=0", capture_en); end
        vectors++; if (pix_cnt !== 17'd1000) begin miscompares++; $display("FAIL stop_pix got=%0d want=1000", pix_cnt); end
        vectors++; if (line_cnt !== 9'd25)   begin miscompares++; $display("FAIL stop_line got=%0d want=25", line_cnt); end
        vsync = 1'b1; cyc(4);
        vectors++; if (frame_cnt !== 16'd2)  begin miscompares++; $display("FAIL stop_fcnt got=%0h want=2", frame_cnt); end
        vectors++; if (done_pulses != pulses_ref) begin miscompares++; $display("FAIL stop_nodone got=%0d want=%0d", done_pulses, pulses_ref); end
    endtask

    task automatic test_start_stop_same();
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ss_busy got=%0h want=0", busy); end
        cyc(2);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ss_busy_late got=%0h want=0", busy); end
    endtask

    task automatic test_overflow();
        pulse_start();
        frame_body(V + 1);
        vectors++; if (pix_cnt !== 17'd1200) begin miscompares++; $display("FAIL ovf_pix got=%0d want=1200", pix_cnt); end
        vectors++; if (line_cnt !== 9'd30)   begin miscompares++; $display("FAIL ovf_line got=%0d want=30", line_cnt); end
        vectors++; if (frame_err !== 1'b1)   begin miscompares++; $display("FAIL ovf_err got=%0h want=1", frame_err); end
        vectors++; if (frame_cnt !== 16'd3)  begin miscompares++; $display("FAIL ovf_fcnt got=%0h want=3", frame_cnt); end
        cyc(1);
        vectors++; if (bank !== exp_bank(1'b1)) begin miscompares++; $display("FAIL ovf_bank got=%0h want=%0h", bank, exp_bank(1'b1)); end
    endtask

    task automatic test_wrap();
        force dut.frame_cnt = 16'hFFFF;
        cyc(1);
        release dut.frame_cnt;
        cyc(1);
        vectors++; if (frame_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_pre got=%0h want=ffff", frame_cnt); end
        pulse_start();
        frame_body(V);
        vectors++; if (frame_cnt !== 16'h0000) begin miscompares++; $display("FAIL wrap_fcnt got=%0h want=0", frame_cnt); end
        vectors++; if (frame_err !== 1'b0)     begin miscompares++; $display("FAIL wrap_err got=%0h want=0", frame_err); end
        cyc(1);
        vectors++; if (bank !== exp_bank(1'b0)) begin miscompares++; $display("FAIL wrap_bank got=%0h want=%0h", bank, exp_bank(1'b0)); end
        pulse_start();
        frame_body(V);
        vectors++; if (frame_cnt !== 16'd1)    begin miscompares++; $display("FAIL wrap_next got=%0h want=1", frame_cnt); end
        cyc(1);
        vectors++; if (bank !== exp_bank(1'b1)) begin miscompares++; $display("FAIL wrap_bank2 got=%0h want=%0h", bank, exp_bank(1'b1)); end
    endtask

    task automatic test_mid_reset();
        pulses_ref = done_pulses;
        pulse_start();
        vsync = 1'b0; cyc(3);
        run_lines(3);
        href = 1'b1; pix_we = 1'b1; cyc(5);
        vectors++; if (pix_cnt !== 17'd125) begin miscompares++; $display("FAIL mr_pre_pix got=%0d want=125", pix_cnt); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL mr_busy got=%0h want=0", busy); end
        vectors++; if (capture_en !== 1'b0) begin miscompares++; $display("FAIL mr_cap got=%0h want=0", capture_en); end
        vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL mr_fcnt got=%0h want=0", frame_cnt); end
        vectors++; if (pix_cnt !== 17'd0)   begin miscompares++; $display("FAIL mr_pix got=%0d want=0", pix_cnt); end
        vectors++; if (line_cnt !== 9'd0)   begin miscompares++; $display("FAIL mr_line got=%0d want=0", line_cnt); end
        vectors++; if (bank !== 1'b0)       begin miscompares++; $display("FAIL mr_bank got=%0h want=0", bank); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mr_done got=%0h want=0", frame_done); end
        href = 1'b0; pix_we = 1'b0; vsync = 1'b1;
        cyc(2); rst = 1'b0; cyc(3);
        vectors++; if (done_pulses != pulses_ref) begin miscompares++; $display("FAIL mr_nodone got=%0d want=%0d", done_pulses, pulses_ref); end
    endtask

    task automatic test_continuous();
        logic b;
        pulses_ref = done_pulses;
        continuous = 1'b1;
        pulse_start();
        cyc(2);
        for (int f = 1; f <= 3; f++) begin
            frame_body(V);
            vectors++; if (frame_cnt !== 16'(f)) begin miscompares++; $display("FAIL cont_fcnt%0d got=%0h want=%0h", f, frame_cnt, f); end
            cyc(1);
            b = exp_bank((f % 2) == 1);
            vectors++; if (bank !== b)     begin miscompares++; $display("FAIL cont_bank%0d got=%0h want=%0h", f, bank, b); end
            vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL cont_rearm%0d got=%0h want=1", f, busy); end
            cyc(2);
        end
        vectors++; if (done_pulses != pulses_ref + 3) begin miscompares++; $display("FAIL cont_pulses got=%0d want=%0d", done_pulses - pulses_ref, 3); end
        continuous = 1'b0;
        stop = 1'b1; cyc(1); stop = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_stop got=%0h want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_stop();
        test_start_stop_same();
        test_overflow();
        test_wrap();
        test_mid_reset();
        test_continuous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
